// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
// cbus_ram_responder : CBus responder backed by a word-addressed RAM
// Revision 1.0 - initial release
// ============================================================================

package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int DEPTH_LOG2   = 12,
  parameter int INIT_LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);

  localparam int AW = DEPTH_LOG2;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      beat, beat_nx;
  logic [3:0]      last_beat, last_beat_nx;
  logic [AW-1:0]   base, base_nx;
  logic            is_wr, is_wr_nx;

  logic [31:0]     mem [2**AW];
  logic [AW-1:0]   beat_addr;
  logic            in_burst;
  logic            final_beat;
  logic            unused_req_bits;

  // Beat address wraps naturally at the array end via the AW-bit add.
  assign beat_addr  = base + AW'(beat);
  assign in_burst   = (state == S_BURST);
  assign final_beat = in_burst && (beat == last_beat);
  assign busy       = (state != S_IDLE);

  assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      beat      <= '0;
      last_beat <= '0;
      base      <= '0;
      is_wr     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      beat      <= beat_nx;
      last_beat <= last_beat_nx;
      base      <= base_nx;
      is_wr     <= is_wr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    beat_nx      = beat;
    last_beat_nx = last_beat;
    base_nx      = base;
    is_wr_nx     = is_wr;
    case (state)
      S_IDLE: begin
        if (creq.valid) begin
          is_wr_nx     = creq.is_write;
          base_nx      = creq.addr[AW+1:2];
          last_beat_nx = creq.len;
          beat_nx      = '0;
          if (INIT_LATENCY == 0) begin
            state_nx = S_BURST;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CW'(INIT_LATENCY);
          end
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = S_BURST;
        end
      end
      S_BURST: begin
        if (final_beat) begin
          state_nx = S_IDLE;
          beat_nx  = '0;
        end else begin
          beat_nx  = beat + 4'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cresp.ready = in_burst;
  assign cresp.last  = final_beat;
  assign cresp.data  = (in_burst && !is_wr) ? mem[beat_addr] : 32'h0;

  // RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (in_burst && is_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) begin
          mem[beat_addr][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cbus_ram_responder.md
# cbus_ram_responder

Responder end of the CBus: accepts `cbus_req_t` transactions from a cache or uncached initiator and answers with `cbus_resp_t` beats, backed by an internal word-addressed RAM. It serves as the on-chip memory model behind the i-/d-cache CBus ports in simulation and small FPGA builds. It supports single and burst reads and writes with per-byte strobes and a configurable initial latency.

## Interface
- `DEPTH_LOG2`, 12: RAM holds 2^DEPTH_LOG2 32-bit words.
- `INIT_LATENCY`, 2: wait cycles between request acceptance and the first beat. 0 is legal.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `creq` in `cbus_req_t`: valid, is_write, size, addr, strobe, data, len.
- `cresp` out `cbus_resp_t`: ready, last, data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, BURST.
- **IDLE**
  - `creq.valid`=1 at the clock edge accepts the request.
  - Latched at acceptance: is_write; word address `creq.addr[DEPTH_LOG2+1:2]`; beat count = len+1 (MLEN1=1, MLEN2=2, MLEN4=4, MLEN8=8, MLEN16=16).
  - Next state is WAIT with the counter loaded to INIT_LATENCY, or BURST if INIT_LATENCY=0.
- **WAIT**: decrement the counter each cycle. Counter at 1 goes to BURST. `creq` is ignored.
- **BURST**: one beat per cycle, `cresp.ready`=1 every cycle.
  - Beat address = latched address + beat index, modulo 2^DEPTH_LOG2 (wraps at the array end).
  - The final beat asserts `cresp.last`=1. The next state is IDLE.
- **Read beat**: `cresp.data` = RAM[beat address], combinational read of the array.
- **Write beat**
  - RAM[beat address] byte lane i is updated with `creq.data[8i+7:8i]` iff `creq.strobe[i]`, at the edge ending the beat.
  - data and strobe are sampled live on each beat. The initiator presents the beat's data while ready is low.
  - `cresp.data` = 0 on writes.
- `creq.size` is not used for address arithmetic. Reads always return the full word, and write lanes are controlled solely by strobe.
- `creq.addr`, len and is_write changing after acceptance have no effect on the transaction in progress.
- Unaligned `addr[1:0]` bits are ignored.
- **Back-to-back**
  - An initiator may hold valid high after seeing last and change the address in the same edge, as in two consecutive uncached fetches.
  - The cycle after last is IDLE, so valid high there is accepted as a new request.
  - There is no required valid-low gap.
- **Reset** (asynchronous, any cycle, including mid-burst)
  - State goes to IDLE, counters clear, and ready, last, data and busy go to 0.
  - A partially completed write burst keeps the beats already written.
  - RAM contents are not cleared by reset.

## Timing
- **Reset values**: `cresp.ready`=0, `cresp.last`=0, `cresp.data`=0, `busy`=0.
- `cresp.ready`, `cresp.last` and `cresp.data` are decoded combinationally from registered state, counter and RAM. They have no combinational path from `creq` except write lanes into RAM at the edge.
- **Request timing**: request valid in cycle 0 in IDLE.
  - WAIT occupies cycles 1..INIT_LATENCY.
  - Beat k (0-based) is in cycle INIT_LATENCY+1+k.
  - last is in cycle INIT_LATENCY+len+1.
  - IDLE is in the following cycle.
- **Throughput**: one read burst of N beats occupies N+INIT_LATENCY+1 cycles including the acceptance cycle.
- `busy` rises the cycle after acceptance and falls the cycle after last.
- A write completes in RAM at the edge ending its beat. A read of the same word starting in the next accepted request sees the new value.

## Test plan
- **Single read, INIT_LATENCY=2**
  - Stimulus: preload RAM[0x10]=0xDEADBEEF; read addr 0x40, MLEN1, valid from cycle 0.
  - Required: ready=last=1 and data=0xDEADBEEF only in cycle 3; busy high in cycles 1–3; IDLE in cycle 4.
- **Burst read MLEN4 at addr 0x100**
  - Stimulus: RAM words 0x40..0x43 = 1,2,3,4.
  - Required: data 1,2,3,4 on consecutive ready cycles 3–6; last only in cycle 6.
- **Strobed write, then read back**
  - Stimulus: RAM[5]=0x11223344; write addr 0x14, MLEN1, strobe 4'b0101, data 0xAABBCCDD; then read addr 0x14.
  - Required: read returns 0x11BB33DD.
- **Back-to-back with valid held high**
  - Stimulus: read 0x0, then change addr to 0x4 on the last cycle and keep valid high.
  - Required: second request accepted the cycle after last; its beat arrives INIT_LATENCY+1 cycles later with RAM[1]; ready never asserted in the gap cycle.
- **Reset mid-burst**
  - Stimulus: MLEN8 write; deassert resetn asynchronously after beat 3.
  - Required: ready, last and busy go to 0 immediately; words 0–3 written, words 4–7 unchanged; a new request after reset follows normal timing.
- **Wrap at array end, DEPTH_LOG2=4**
  - Stimulus: MLEN4 read at word 14.
  - Required: returns words 14, 15, 0, 1.
